reg_file_sb: RTL

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_pkg.sv | 26 ++
 rtl/rf_scoreboard.sv | 68 ++++++
 rtl/reg_file_sb.sv | 113 +++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared defaults and address-width derivation for the
//               scoreboarded register file.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    // Smallest w such that 2**w >= n; used to size register addresses.
    function automatic int calc_aw(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Per-register busy bits with flush > issue > write-clear
//               priority, plus a registered population count.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    localparam int AW   = calc_aw(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_en0,
    input  logic [AW-1:0]    w_addr0,
    input  logic             w_en1,
    input  logic [AW-1:0]    w_addr1,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      pend_cnt
);

    logic [NREGS-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;

    // Next busy vector: writes clear, a same-cycle issue re-arms, flush wins.
    always_comb begin
        busy_nxt = busy;
        if (w_en0) begin
            busy_nxt[w_addr0] = 1'b0;
        end
        if (w_en1) begin
            busy_nxt[w_addr1] = 1'b0;
        end
        if (iss_en) begin
            busy_nxt[iss_addr] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
        busy_nxt[0] = 1'b0;
    end

    // Population count of the next vector so pend_cnt tracks busy exactly.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
        end
    end

    // Busy bits and pending count update together on each edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb
// Description : Two-read / two-write register file with optional same-cycle
//               write forwarding and an issue scoreboard. Register 0 is
//               hard-wired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int BYPASS = 1,
    localparam int AW    = calc_aw(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   r_addr0,
    input  logic [AW-1:0]   r_addr1,
    output logic [XLEN-1:0] r_data0,
    output logic [XLEN-1:0] r_data1,
    output logic            r_busy0,
    output logic            r_busy1,
    input  logic            w_en0,
    input  logic [AW-1:0]   w_addr0,
    input  logic [XLEN-1:0] w_data0,
    input  logic            w_en1,
    input  logic [AW-1:0]   w_addr1,
    input  logic [XLEN-1:0] w_data1,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    input  logic            flush,
    output logic [AW:0]     pend_cnt
);

    localparam bit FWD = (BYPASS != 0);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic             wr0_live;
    logic             wr1_live;

    // Writes to register 0 are discarded so they can neither store nor forward.
    assign wr0_live = w_en0 && (w_addr0 != '0);
    assign wr1_live = w_en1 && (w_addr1 != '0);

    // Storage: port 1 is applied last so it wins an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr0_live) begin
                regs[w_addr0] <= w_data0;
            end
            if (wr1_live) begin
                regs[w_addr1] <= w_data1;
            end
        end
    end

    // Read port 0: stored value, optionally overridden by a live write.
    always_comb begin
        r_data0 = regs[r_addr0];
        if (FWD && wr0_live && (w_addr0 == r_addr0)) begin
            r_data0 = w_data0;
        end
        if (FWD && wr1_live && (w_addr1 == r_addr0)) begin
            r_data0 = w_data1;
        end
        if (r_addr0 == '0) begin
            r_data0 = '0;
        end
    end

    // Read port 1: identical forwarding priority to port 0.
    always_comb begin
        r_data1 = regs[r_addr1];
        if (FWD && wr0_live && (w_addr0 == r_addr1)) begin
            r_data1 = w_data0;
        end
        if (FWD && wr1_live && (w_addr1 == r_addr1)) begin
            r_data1 = w_data1;
        end
        if (r_addr1 == '0) begin
            r_data1 = '0;
        end
    end

    // Busy flags come straight from the stored vector; no same-cycle bypass.
    assign r_busy0 = busy[r_addr0];
    assign r_busy1 = busy[r_addr1];

    rf_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .w_en0    (wr0_live),
        .w_addr0  (w_addr0),
        .w_en1    (wr1_live),
        .w_addr1  (w_addr1),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy     (busy),
        .pend_cnt (pend_cnt)
    );

endmodule
`default_nettype wire
